instr_dispatcher: RTL

Sequencer that walks the instruction memory and issues each 16-bit instruction to the addressed processor/cache controller of the MSI snooping system.
- Drives the memory address, registers the returned instruction and decodes it as processor[15:13], write/read[12], tag[11:7], immediate[6:0].
- Runs a one-hot request/done handshake with the target processor, one transaction at a time, so bus transactions stay strictly ordered.
- Sits directly upstream of the cache/bus logic and downstream of the instruction memory.

---
 rtl/instr_dispatcher_if.sv | 22 ++
 rtl/instr_dispatcher.sv | 139 +++++++++++++
 2 files changed

// File: rtl/instr_dispatcher_if.sv
// Instruction-memory and processor-request bus between the dispatcher and its neighbours.
interface instr_dispatcher_if #(
   parameter int N_PROC = 4
) ();
   logic [7:0]        endereco;
   logic [15:0]       instr;
   logic [N_PROC-1:0] proc_req;
   logic              op_write;
   logic [4:0]        tag;
   logic [6:0]        dado;
   logic              proc_done;

   modport master (
      output endereco, proc_req, op_write, tag, dado,
      input  instr, proc_done
   );

   modport slave (
      input  endereco, proc_req, op_write, tag, dado,
      output instr, proc_done
   );
endinterface

// File: rtl/instr_dispatcher.sv
// Walks instruction memory and issues each instruction to its processor with a one-hot
// request/done handshake, one transaction at a time.
module instr_dispatcher #(
   parameter int NUM_INSTR = 11,
   parameter int N_PROC    = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   instr_dispatcher_if.master bus,
   output logic               busy,
   output logic               finished,
   output logic               erro,
   output logic [7:0]         instr_count
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, NEXT, FINISHED} state_t;

   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
   localparam logic [7:0]     LAST   = 8'(NUM_INSTR - 1);

   state_t            state, state_n;
   logic [15:0]       ir;
   logic [WDW-1:0]    wd;
   logic [7:0]        endereco;
   logic [N_PROC-1:0] proc_req;
   logic              op_write;
   logic [4:0]        tag;
   logic [6:0]        dado;
   logic [N_PROC-1:0] onehot;
   logic              valid_p;
   logic              timeout;
   logic [7:0]        count_inc;

   assign bus.endereco = endereco;
   assign bus.proc_req = proc_req;
   assign bus.op_write = op_write;
   assign bus.tag      = tag;
   assign bus.dado     = dado;

   assign valid_p   = 32'(ir[15:13]) < N_PROC;
   assign onehot    = N_PROC'(1) << ir[15:13];
   assign timeout   = (wd == WD_MAX);
   assign count_inc = (instr_count == 8'hFF) ? instr_count : instr_count + 8'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      busy     = 1'b0;
      finished = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_n = (NUM_INSTR == 0) ? FINISHED : FETCH;
         end
         FETCH: begin
            busy    = 1'b1;
            state_n = ISSUE;
         end
         ISSUE: begin
            busy    = 1'b1;
            state_n = valid_p ? WAIT : NEXT;
         end
         WAIT: begin
            busy = 1'b1;
            if (bus.proc_done || timeout) state_n = NEXT;
         end
         NEXT: begin
            busy    = 1'b1;
            state_n = (endereco == LAST) ? FINISHED : FETCH;
         end
         FINISHED: begin
            finished = 1'b1;
            if (start) state_n = (NUM_INSTR == 0) ? FINISHED : FETCH;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         endereco    <= '0;
         ir          <= '0;
         wd          <= '0;
         proc_req    <= '0;
         op_write    <= 1'b0;
         tag         <= '0;
         dado        <= '0;
         erro        <= 1'b0;
         instr_count <= '0;
      end else begin
         unique case (state)
            IDLE, FINISHED: begin
               if (start) begin
                  endereco    <= '0;
                  instr_count <= '0;
                  erro        <= 1'b0;
               end
            end
            FETCH: ir <= bus.instr;
            ISSUE: begin
               if (valid_p) begin
                  proc_req <= onehot;
                  op_write <= ir[12];
                  tag      <= ir[11:7];
                  dado     <= ir[6:0];
                  wd       <= '0;
               end else begin
                  erro        <= 1'b1;
                  instr_count <= count_inc;
               end
            end
            WAIT: begin
               // done wins over a simultaneous watchdog expiry
               if (bus.proc_done) begin
                  proc_req    <= '0;
                  instr_count <= count_inc;
               end else if (timeout) begin
                  proc_req    <= '0;
                  erro        <= 1'b1;
                  instr_count <= count_inc;
               end else begin
                  wd <= wd + WDW'(1);
               end
            end
            NEXT: begin
               if (endereco != LAST) endereco <= endereco + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
